// File: rtl/instruction_memory.sv
// Word-addressed instruction store with a one-cycle registered read port.
// Contents come from a hierarchical backdoor preload of Memory.
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module instruction_memory #(
  parameter int    ADDR_BITS = 10,
  parameter int    MEM_SIZE  = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_BITS-1:0]  address,
  output logic [`DATA_BITS-1:0] instruction
);

  localparam int IDX_BITS = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  logic [`DATA_BITS-1:0] Memory [0:MEM_SIZE-1];

  logic [`DATA_BITS-1:0] instruction_q;
  logic [`DATA_BITS-1:0] instruction_d;
  logic [IDX_BITS-1:0]   rd_idx;
  logic                  in_range;

  // The range check runs on the full address so out-of-range reads never alias onto a low word.
  assign in_range = ({{(32-ADDR_BITS){1'b0}}, address} < MEM_SIZE);
  assign rd_idx   = address[IDX_BITS-1:0];

  always_comb begin
    instruction_d = '0;
    if (in_range) instruction_d = Memory[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) instruction_q <= '0;
    else     instruction_q <= instruction_d;
  end

  assign instruction = instruction_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: expected words queued when an address is driven,
// popped and checked one rising edge later.
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module tb_instruction_memory;

  localparam int AB = 10;
  localparam int MS = 100;

  logic                  clk;
  logic                  rst;
  logic [AB-1:0]         address;
  logic [`DATA_BITS-1:0] instruction;

  logic [`DATA_BITS-1:0] mdl [0:MS-1];
  logic [`DATA_BITS-1:0] expq [$];
  int vectors;
  int miscompares;

  instruction_memory #(.ADDR_BITS(AB), .MEM_SIZE(MS), .INIT_FILE("")) dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .instruction (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bd(input int i, input logic [`DATA_BITS-1:0] v);
    dut.Memory[i] = v;
    mdl[i]        = v;
  endtask

  task automatic check(input string tag, input logic [`DATA_BITS-1:0] obs,
                       input logic [`DATA_BITS-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one address on the falling edge, queue the expected word, check after the rising edge.
  task automatic step(input string tag, input logic r, input logic [AB-1:0] a);
    logic [`DATA_BITS-1:0] e;
    @(negedge clk);
    rst     = r;
    address = a;
    if (r)                  e = '0;
    else if (int'(a) < MS)  e = mdl[a];
    else                    e = '0;
    expq.push_back(e);
    @(posedge clk);
    #1;
    if (expq.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      check(tag, instruction, expq.pop_front());
    end
  endtask

  initial begin
    logic [`DATA_BITS-1:0] held;
    logic [`DATA_BITS-1:0] e;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    address     = '0;
    for (int i = 0; i < MS; i++) bd(i, i);

    step("reset0", 1'b1, 10'd0);
    step("reset1", 1'b1, 10'd0);

    for (int i = 0; i < MS; i++) step("sweep", (i == 50), AB'(i));

    bd(5, 32'hDEADBEEF);
    step("rst_hold0", 1'b1, 10'd5);
    step("rst_hold1", 1'b1, 10'd5);
    step("rst_release", 1'b0, 10'd5);

    bd(7, 32'h00A00093);
    for (int i = 0; i < 5; i++) step("hold7", 1'b0, 10'd7);

    step("oor100", 1'b0, 10'd100);
    step("oor1023", 1'b0, 10'd1023);
    bd(99, 32'h12345678);
    step("top_word", 1'b0, 10'd99);
    step("oor_again", 1'b0, 10'd512);

    step("pre_glitch", 1'b0, 10'd3);
    held = instruction;
    @(negedge clk);
    address = 10'd3;
    #2;
    address = 10'd4;
    #1;
    check("no_comb_path", instruction, mdl[3]);
    e = mdl[4];
    expq.push_back(e);
    @(posedge clk);
    #1;
    check("edge_value", instruction, expq.pop_front());
    #2;
    address = 10'd9;
    #1;
    check("stable_mid", instruction, mdl[4]);
    if (held !== mdl[3]) begin
      vectors++;
      miscompares++;
      $error("FAIL held3: got %h expected %h", held, mdl[3]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
